// File: rtl/atari_pixel_capture.sv
// Captures the TIA raster stream as visible-pixel records {y, x, color} and queues
// them in a show-ahead FIFO drained by the SRAM writer; overflow drops are counted.
module atari_pixel_capture #(
  parameter int DEPTH = 512,
  parameter int MAX_X = 160,
  parameter int MAX_Y = 256
) (
  input  logic                     CLOCKPIXEL,
  input  logic                     RES_n,
  input  logic                     HBLANK,
  input  logic                     VBLANK,
  input  logic [7:0]               COLOROUT,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_x,
  output logic [8:0]               out_y,
  output logic [7:0]               out_color,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_start,
  output logic                     frame_ovf,
  output logic [15:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [8:0]    MAX_X_L = 9'(MAX_X);
  localparam logic [9:0]    MAX_Y_L = 10'(MAX_Y);
  localparam logic [LW-1:0] FULL_L  = LW'(DEPTH);

  logic          s_hb_q, s_hb_d, s_vb_q, s_vb_d;
  logic          s_hb_dly_q, s_hb_dly_d, s_vb_dly_q, s_vb_dly_d;
  logic [7:0]    s_col_q, s_col_d;
  logic [7:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic          push_q, push_d;
  logic [24:0]   rec_q, rec_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          frame_start_q, frame_start_d;
  logic          frame_ovf_q, frame_ovf_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic [24:0]   mem_q [DEPTH];

  logic hb_rise, vb_fall, eligible, full, empty, pop, wr_en, drop;
  logic [24:0] head;

  always_comb begin
    s_hb_d     = HBLANK;
    s_vb_d     = VBLANK;
    s_col_d    = COLOROUT;
    s_hb_dly_d = s_hb_q;
    s_vb_dly_d = s_vb_q;

    hb_rise  = s_hb_q & ~s_hb_dly_q;
    vb_fall  = ~s_vb_q & s_vb_dly_q;
    eligible = ~s_hb_q & ~s_vb_q & ({1'b0, x_q} < MAX_X_L) & ({1'b0, y_q} < MAX_Y_L);

    full  = (level_q == FULL_L);
    empty = (level_q == {LW{1'b0}});
    pop   = ~empty & out_ready;
    // At full a push only lands when the head leaves in the same cycle.
    wr_en = push_q & (~full | pop);
    drop  = push_q & full & ~pop;

    if (s_hb_q) begin
      x_d = 8'd0;
    end else if (x_q == 8'hFF) begin
      x_d = x_q;
    end else begin
      x_d = x_q + 8'd1;
    end

    if (s_vb_q) begin
      y_d = 9'd0;
    end else if (hb_rise && (y_q != 9'h1FF)) begin
      y_d = y_q + 9'd1;
    end else begin
      y_d = y_q;
    end

    push_d   = eligible;
    rec_d    = {y_q, x_q, s_col_q};
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(wr_en) - LW'(pop);

    frame_start_d = vb_fall;
    if (drop) begin
      frame_ovf_d = 1'b1;
    end else if (vb_fall) begin
      frame_ovf_d = 1'b0;
    end else begin
      frame_ovf_d = frame_ovf_q;
    end

    if (drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  always_ff @(posedge CLOCKPIXEL) begin
    if (!RES_n) begin
      s_hb_q        <= 1'b1;
      s_vb_q        <= 1'b1;
      s_hb_dly_q    <= 1'b1;
      s_vb_dly_q    <= 1'b1;
      s_col_q       <= 8'd0;
      x_q           <= 8'd0;
      y_q           <= 9'd0;
      push_q        <= 1'b0;
      rec_q         <= 25'd0;
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      level_q       <= {LW{1'b0}};
      frame_start_q <= 1'b0;
      frame_ovf_q   <= 1'b0;
      drop_count_q  <= 16'd0;
    end else begin
      s_hb_q        <= s_hb_d;
      s_vb_q        <= s_vb_d;
      s_hb_dly_q    <= s_hb_dly_d;
      s_vb_dly_q    <= s_vb_dly_d;
      s_col_q       <= s_col_d;
      x_q           <= x_d;
      y_q           <= y_d;
      push_q        <= push_d;
      rec_q         <= rec_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      frame_start_q <= frame_start_d;
      frame_ovf_q   <= frame_ovf_d;
      drop_count_q  <= drop_count_d;
    end
  end

  // Storage is not reset; the pointer reset is what flushes it.
  always_ff @(posedge CLOCKPIXEL) begin
    if (RES_n && wr_en) begin
      mem_q[wr_ptr_q] <= rec_q;
    end
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_valid = ~empty;
    if (out_valid) begin
      out_y     = head[24:16];
      out_x     = head[15:8];
      out_color = head[7:0];
    end else begin
      out_y     = 9'd0;
      out_x     = 8'd0;
      out_color = 8'd0;
    end
  end

  assign level       = level_q;
  assign frame_start = frame_start_q;
  assign frame_ovf   = frame_ovf_q;
  assign drop_count  = drop_count_q;

endmodule
